if_ctrl: RTL and testbench
==========================

IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default `PC_WIDTH, the width of the PC and IMEM byte address.
REQ-002 SHALL have parameter INST_WIDTH, default `INST_WIDTH, the instruction word width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, the register index width.
REQ-004 SHALL have parameter MAX_WORDS, default 64, the IMEM capacity in words.
REQ-005 SHALL have one clock and a synchronous, active-high reset; clk in 1 is the single clock, all state updates on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 ld_valid in 1; ld_last in 1; ld_data in INST_WIDTH: boot-load word stream.
REQ-008 ld_ready out 1: load word accepted this cycle.
REQ-009 imem_wr_en out 1; imem_wr_addr out PC_WIDTH; imem_wr_data out INST_WIDTH: IMEM write port.
REQ-010 ID_EX_mem_read in 1; ID_EX_rd in REG_ADDR_WIDTH; IF_ID_rs1 in REG_ADDR_WIDTH; IF_ID_rs2 in REG_ADDR_WIDTH: load-use hazard inputs.
REQ-011 br_taken in 1; br_target in PC_WIDTH: resolved branch from EX.
REQ-012 halt_req in 1: level request to freeze fetch.
REQ-013 pc_write out 1; IF_ID_write out 1; pc_sel out 1; pc_imm out PC_WIDTH: IF stage controls.
REQ-014 IF_ID_flush out 1; ID_EX_flush out 1: bubble insertion.
REQ-015 state out 2; stall_cnt out 16; flush_cnt out 16: status.

Function
REQ-016 FSM states SHALL be LOAD=0, RUN=1, FLUSH=2, HALT=3.
REQ-017 LOAD: ld_ready=1; on ld_valid, imem_wr_en=1, imem_wr_addr=word_cnt*4, imem_wr_data=ld_data, word_cnt increments.
REQ-018 LOAD: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1.
REQ-019 LOAD->RUN next cycle on ld_valid&&ld_last, or on an accepted word with word_cnt==MAX_WORDS-1; word_cnt does not wrap.
REQ-020 Outside LOAD: ld_ready=0, imem_wr_en=0, ld_valid ignored.
REQ-021 RUN default: pc_write=1, IF_ID_write=1, pc_sel=0, flushes 0.
REQ-022 hazard = ID_EX_mem_read && ID_EX_rd!=0 && (ID_EX_rd==IF_ID_rs1 || ID_EX_rd==IF_ID_rs2).
REQ-023 RUN priority: br_taken > halt_req > hazard, all decoded combinationally the same cycle.
REQ-024 RUN, br_taken: pc_sel=1, pc_imm=br_target, pc_write=1, IF_ID_flush=1, ID_EX_flush=1; next state FLUSH; flush_cnt+1.
REQ-025 RUN, halt_req, no br_taken: pc_write=0, IF_ID_write=0; next state HALT.
REQ-026 RUN, hazard only: pc_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cnt+1; state stays RUN.
REQ-027 FLUSH: lasts exactly 1 cycle; br_taken and hazard ignored; ID_EX_flush=1, pc_write=1, IF_ID_write=1; next RUN.
REQ-028 HALT: pc_write=0, IF_ID_write=0, flushes 0; HALT->RUN the cycle after halt_req deasserts.
REQ-029 pc_imm SHALL equal br_target whenever pc_sel=1, else 0.
REQ-030 stall_cnt and flush_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-031 On reset=1 at a clock edge: state=LOAD, word_cnt=0, stall_cnt=0, flush_cnt=0, from any state including mid-load.
REQ-032 While reset is asserted, the outputs SHALL be the LOAD values of REQ-017/018 with imem_wr_en=0 and ld_ready=0.

Structure
REQ-033 State encodings and the MAX_WORDS default SHALL be defined in the shared risc_v_defines include.
REQ-034 The saturating counter SHALL be one sub-module, sat_cnt16, instantiated twice.
REQ-035 Next-state and output decode SHALL be a single combinational block with registered state only.

Verification
REQ-036 Load 3 words (0x00E60433, 0x40860533, 0xFCE50793), last on the 3rd -> writes at addr 0x0,0x4,0x8; state=RUN on the following cycle.
REQ-037 Load MAX_WORDS words with no ld_last -> RUN after word 63; a 65th ld_valid produces no write.
REQ-038 RUN with ID_EX_mem_read=1, ID_EX_rd=14, IF_ID_rs2=14 -> pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_cnt=1; with rd=0 -> no stall.
REQ-039 RUN with br_taken=1, br_target=0x48 and a simultaneous hazard -> pc_sel=1, pc_imm=0x48, both flushes=1, stall_cnt unchanged; FLUSH for 1 cycle, then RUN; flush_cnt=1.
REQ-040 halt_req held for 4 cycles in RUN -> 4 cycles of pc_write=0, then RUN one cycle after deassert; br_taken during HALT ignored.
REQ-041 Reset asserted after 2 of 5 load words -> state=LOAD, word_cnt=0; the next accepted word writes addr 0x0.

Source files
------------

// File: rtl/if_ctrl_pkg.sv
// Shared RISC-V front-end definitions plus the types and helpers used by the
// instruction-fetch controller.
`ifndef RISC_V_DEFINES_SVH
`define RISC_V_DEFINES_SVH
`define PC_WIDTH    32
`define INST_WIDTH  32
`define MAX_WORDS   64
`define IF_ST_LOAD  2'd0
`define IF_ST_RUN   2'd1
`define IF_ST_FLUSH 2'd2
`define IF_ST_HALT  2'd3
`endif

package if_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = `IF_ST_LOAD,
    ST_RUN   = `IF_ST_RUN,
    ST_FLUSH = `IF_ST_FLUSH,
    ST_HALT  = `IF_ST_HALT
  } if_state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
  import if_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = sat_inc16(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: boot-loads IMEM, then steers PC/IF-ID updates
// for branches, halts and load-use stalls.
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int PC_WIDTH       = `PC_WIDTH,
  parameter int INST_WIDTH     = `INST_WIDTH,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WORDS      = `MAX_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_valid,
  input  logic                      ld_last,
  input  logic [INST_WIDTH-1:0]     ld_data,
  output logic                      ld_ready,
  output logic                      imem_wr_en,
  output logic [PC_WIDTH-1:0]       imem_wr_addr,
  output logic [INST_WIDTH-1:0]     imem_wr_data,
  input  logic                      ID_EX_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      br_taken,
  input  logic [PC_WIDTH-1:0]       br_target,
  input  logic                      halt_req,
  output logic                      pc_write,
  output logic                      IF_ID_write,
  output logic                      pc_sel,
  output logic [PC_WIDTH-1:0]       pc_imm,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_flush,
  output logic [1:0]                state,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               flush_cnt
);

  // one spare bit so the count can reach MAX_WORDS without wrapping
  localparam int WC_W = $clog2(MAX_WORDS) + 1;

  if_state_e       state_q, state_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic            hazard;
  logic            stall_inc;
  logic            flush_inc;

  assign hazard = ID_EX_mem_read && (ID_EX_rd != '0) &&
                  ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

  // next-state and output decode
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    state        = state_q;
    ld_ready     = 1'b0;
    imem_wr_en   = 1'b0;
    imem_wr_addr = '0;
    imem_wr_data = '0;
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    pc_sel       = 1'b0;
    pc_imm       = '0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (reset) begin
      state_d     = ST_LOAD;
      word_cnt_d  = '0;
      state       = ST_LOAD;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          ld_ready    = 1'b1;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          if (ld_valid) begin
            imem_wr_en   = 1'b1;
            imem_wr_addr = PC_WIDTH'({word_cnt_q, 2'b00});
            imem_wr_data = ld_data;
            word_cnt_d   = word_cnt_q + WC_W'(1);
            if (ld_last || (word_cnt_q == WC_W'(MAX_WORDS - 1))) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_RUN: begin
          pc_write    = 1'b1;
          IF_ID_write = 1'b1;
          // branch outranks halt, halt outranks the load-use stall
          if (br_taken) begin
            pc_sel      = 1'b1;
            pc_imm      = br_target;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = ST_FLUSH;
          end else if (halt_req) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            state_d     = ST_HALT;
          end else if (hazard) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            stall_inc   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          pc_write    = 1'b1;
          IF_ID_write = 1'b1;
          ID_EX_flush = 1'b1;
          state_d     = ST_RUN;
        end
        ST_HALT: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  // state and load-pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_if_ctrl.sv
// Scoreboard bench for if_ctrl: a behavioural model predicts every cycle's
// outputs and every IMEM write; a negedge monitor compares what the DUT shows.
module tb_if_ctrl;

  localparam int PCW = 32;
  localparam int IW  = 32;
  localparam int RW  = 5;
  localparam int MW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, ld_valid, ld_last, ld_ready;
  logic [IW-1:0]  ld_data, imem_wr_data;
  logic           imem_wr_en;
  logic [PCW-1:0] imem_wr_addr, br_target, pc_imm;
  logic           ID_EX_mem_read, br_taken, halt_req;
  logic [RW-1:0]  ID_EX_rd, IF_ID_rs1, IF_ID_rs2;
  logic           pc_write, IF_ID_write, pc_sel, IF_ID_flush, ID_EX_flush;
  logic [1:0]     state;
  logic [15:0]    stall_cnt, flush_cnt;

  if_ctrl #(.PC_WIDTH(PCW), .INST_WIDTH(IW), .REG_ADDR_WIDTH(RW), .MAX_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data),
    .ld_ready(ld_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req), .pc_write(pc_write), .IF_ID_write(IF_ID_write), .pc_sel(pc_sel),
    .pc_imm(pc_imm), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic           ld_ready;
    logic           wr_en;
    logic [PCW-1:0] wr_addr;
    logic [IW-1:0]  wr_data;
    logic           pc_write;
    logic           if_id_write;
    logic           pc_sel;
    logic [PCW-1:0] pc_imm;
    logic           if_id_flush;
    logic           id_ex_flush;
    logic [1:0]     state;
    logic [15:0]    stall_cnt;
    logic [15:0]    flush_cnt;
  } obs_t;

  obs_t                exp_q[$];
  logic [PCW+IW-1:0]   wr_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // reference model: 0=LOAD 1=RUN 2=FLUSH 3=HALT
  int m_mode, m_wc, m_stall, m_flush;

  // monitor: compares the DUT against the oldest prediction every cycle
  always @(negedge clk) begin
    obs_t a_v, e_v;
    logic [PCW+IW-1:0] w_v;
    a_v = '{ld_ready, imem_wr_en, imem_wr_addr, imem_wr_data, pc_write, IF_ID_write,
            pc_sel, pc_imm, IF_ID_flush, ID_EX_flush, state, stall_cnt, flush_cnt};
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      vectors++;
      if (a_v !== e_v) begin
        miscompares++;
        $display("FAIL ctrl t=%0t got=%h expected=%h", $time, a_v, e_v);
      end
    end
    if (imem_wr_en === 1'b1) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL imem_write t=%0t got=%h_%h expected=no write", $time, imem_wr_addr, imem_wr_data);
      end else begin
        w_v = wr_q.pop_front();
        if ({imem_wr_addr, imem_wr_data} !== w_v) begin
          miscompares++;
          $display("FAIL imem_write t=%0t got=%h_%h expected=%h", $time, imem_wr_addr, imem_wr_data, w_v);
        end
      end
    end
  end

  task automatic clr();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    ID_EX_mem_read = 1'b0; ID_EX_rd = '0; IF_ID_rs1 = '0; IF_ID_rs2 = '0;
    br_taken = 1'b0; br_target = '0; halt_req = 1'b0;
  endtask

  // predict this cycle, advance the model, then move to the next cycle
  task automatic apply();
    obs_t e;
    bit hz;
    e = '0;
    e.state     = 2'(m_mode);
    e.stall_cnt = 16'(m_stall);
    e.flush_cnt = 16'(m_flush);
    hz = ID_EX_mem_read && (ID_EX_rd != 0) && (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
    if (reset) begin
      e.state = 2'd0; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
      m_mode = 0; m_wc = 0; m_stall = 0; m_flush = 0;
    end else if (m_mode == 0) begin
      e.ld_ready = 1'b1; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
      if (ld_valid) begin
        e.wr_en = 1'b1; e.wr_addr = PCW'(m_wc * 4); e.wr_data = ld_data;
        wr_q.push_back({e.wr_addr, ld_data});
        if (ld_last || m_wc == MW - 1) m_mode = 1;
        m_wc++;
      end
    end else if (m_mode == 1) begin
      if (br_taken) begin
        e.pc_write = 1'b1; e.if_id_write = 1'b1; e.pc_sel = 1'b1; e.pc_imm = br_target;
        e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
        m_mode = 2;
        if (m_flush < 65535) m_flush++;
      end else if (halt_req) begin
        m_mode = 3;
      end else if (hz) begin
        e.id_ex_flush = 1'b1;
        if (m_stall < 65535) m_stall++;
      end else begin
        e.pc_write = 1'b1; e.if_id_write = 1'b1;
      end
    end else if (m_mode == 2) begin
      e.pc_write = 1'b1; e.if_id_write = 1'b1; e.id_ex_flush = 1'b1;
      m_mode = 1;
    end else begin
      if (!halt_req) m_mode = 1;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [IW-1:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    apply();
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; apply(); reset = 1'b0;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    m_mode = 0; m_wc = 0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // three-word boot image, then idle RUN
    load(32'h00E60433, 1'b0);
    load(32'h40860533, 1'b0);
    load(32'hFCE50793, 1'b1);
    repeat (2) apply();

    // load-use stall, then rd=0 never stalls
    ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd14; IF_ID_rs2 = 5'd14; apply();
    ID_EX_rd = 5'd0; IF_ID_rs2 = 5'd0; apply();
    clr(); apply();

    // branch beats a simultaneous hazard
    ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd14; IF_ID_rs2 = 5'd14;
    br_taken = 1'b1; br_target = 32'h0000_0048; apply();
    clr(); repeat (2) apply();

    // halt for four cycles, branch during HALT is ignored
    halt_req = 1'b1; apply();
    br_taken = 1'b1; br_target = 32'h0000_0080; repeat (3) apply();
    halt_req = 1'b0; apply();
    clr(); repeat (2) apply();

    // reset in the middle of a load restarts the address at zero
    do_reset();
    load(32'h1111_1111, 1'b0);
    load(32'h2222_2222, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) load($urandom(), (i == 4));
    apply();

    // full-capacity load without ld_last, then one extra word
    do_reset();
    for (int i = 0; i < MW; i++) load($urandom(), 1'b0);
    load(32'hDEAD_BEEF, 1'b0);
    apply();

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(199) == 0);
      ld_valid       = 1'($urandom_range(1));
      ld_last        = ($urandom_range(7) == 0);
      ld_data        = $urandom();
      ID_EX_mem_read = 1'($urandom_range(1));
      ID_EX_rd       = RW'($urandom_range(3));
      IF_ID_rs1      = RW'($urandom_range(3));
      IF_ID_rs2      = RW'($urandom_range(3));
      br_taken       = ($urandom_range(9) == 0);
      br_target      = $urandom();
      if ($urandom_range(7) == 0) halt_req = ~halt_req;
      apply();
    end
    reset = 1'b0;
    clr();

    // stall counter saturation
    do_reset();
    load(32'h0000_0013, 1'b1);
    ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd3; IF_ID_rs1 = 5'd3;
    repeat (65540) apply();
    clr(); apply();

    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d/%0d pending expected=0/0", exp_q.size(), wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
